// File: rtl/kbd_mouse_sched.sv
// Keyboard/mouse event scheduler: buffers keycodes behind a valid/ack handshake with
// an enforced inter-code gap, holds the latest OSD key, and accumulates mouse deltas.
module kbd_mouse_sched #(
  parameter int unsigned KBD_DEPTH = 8,
  parameter int unsigned KBD_GAP   = 16
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       kms_strobe,
  input  logic [1:0] kms_type,
  input  logic [7:0] kms_data,
  input  logic       kms_idx,
  output logic       kbd_valid,
  output logic [7:0] kbd_code,
  input  logic       kbd_ack,
  output logic       kbd_ovf,
  input  logic       ovf_clr,
  output logic       osd_valid,
  output logic [7:0] osd_code,
  input  logic       osd_ack,
  output logic [7:0] m0_x,
  output logic [7:0] m0_y,
  output logic [7:0] m0_w,
  output logic [7:0] m1_x,
  output logic [7:0] m1_y,
  output logic [7:0] m1_w
);

  localparam int unsigned AW = $clog2(KBD_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} kbd_state_e;

  kbd_state_e    state_q, state_d;
  logic [7:0]    gap_q, gap_d;
  logic          valid_q, valid_d;
  logic [7:0]    code_q, code_d;
  logic [7:0]    mem_q [KBD_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q;
  logic          osd_valid_q;
  logic [7:0]    osd_code_q;
  logic [1:0]    phase_q;
  logic          sel_q;
  logic [7:0]    mx_q [2];
  logic [7:0]    my_q [2];
  logic [7:0]    mw_q [2];

  logic push, pop, full, empty, push_ok;

  assign push    = kms_strobe && (kms_type == 2'd2);
  assign full    = (cnt_q == CW'(KBD_DEPTH));
  assign empty   = (cnt_q == '0);
  // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    code_d  = code_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          code_d  = mem_q[rd_ptr_q];
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (kbd_ack) begin
          valid_d = 1'b0;
          gap_d   = 8'(KBD_GAP);
          state_d = (KBD_GAP == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q <= 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      valid_q  <= 1'b0;
      code_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      ovf_q <= (push && !push_ok) || (ovf_q && !ovf_clr);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_q[wr_ptr_q] <= kms_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      osd_valid_q <= 1'b0;
      osd_code_q  <= '0;
    end else if (kms_strobe && (kms_type == 2'd3)) begin
      osd_valid_q <= 1'b1;
      osd_code_q  <= kms_data;
    end else if (osd_ack) begin
      osd_valid_q <= 1'b0;
    end
  end

  // Y and wheel go to the mouse latched by the preceding X strobe, not the current kms_idx.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
      sel_q   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        mx_q[i] <= '0;
        my_q[i] <= '0;
        mw_q[i] <= '0;
      end
    end else if (kms_strobe) begin
      unique case (kms_type)
        2'd0: begin
          mx_q[kms_idx] <= mx_q[kms_idx] + kms_data;
          phase_q       <= 2'd1;
          sel_q         <= kms_idx;
        end
        2'd1: begin
          if (phase_q == 2'd1) begin
            my_q[sel_q] <= my_q[sel_q] + kms_data;
            phase_q     <= 2'd2;
          end else if (phase_q == 2'd2) begin
            mw_q[sel_q] <= mw_q[sel_q] + kms_data;
            phase_q     <= 2'd0;
          end
        end
        default: phase_q <= 2'd0;
      endcase
    end
  end

  assign kbd_valid = valid_q;
  assign kbd_code  = code_q;
  assign kbd_ovf   = ovf_q;
  assign osd_valid = osd_valid_q;
  assign osd_code  = osd_code_q;
  assign m0_x      = mx_q[0];
  assign m0_y      = my_q[0];
  assign m0_w      = mw_q[0];
  assign m1_x      = mx_q[1];
  assign m1_y      = my_q[1];
  assign m1_w      = mw_q[1];

endmodule

// File: tb/tb_kbd_mouse_sched.sv
// Randomized and directed bench for kbd_mouse_sched against a queue-based reference model.
module tb_kbd_mouse_sched;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned GAPC  = 16;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       kms_strobe = 1'b0;
  logic [1:0] kms_type = '0;
  logic [7:0] kms_data = '0;
  logic       kms_idx = 1'b0;
  logic       kbd_valid, kbd_ovf, osd_valid;
  logic [7:0] kbd_code, osd_code;
  logic       kbd_ack = 1'b0, ovf_clr = 1'b0, osd_ack = 1'b0;
  logic [7:0] m0_x, m0_y, m0_w, m1_x, m1_y, m1_w;

  kbd_mouse_sched #(.KBD_DEPTH(DEPTH), .KBD_GAP(GAPC)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .kms_strobe(kms_strobe), .kms_type(kms_type),
    .kms_data(kms_data), .kms_idx(kms_idx), .kbd_valid(kbd_valid), .kbd_code(kbd_code),
    .kbd_ack(kbd_ack), .kbd_ovf(kbd_ovf), .ovf_clr(ovf_clr), .osd_valid(osd_valid),
    .osd_code(osd_code), .osd_ack(osd_ack), .m0_x(m0_x), .m0_y(m0_y), .m0_w(m0_w),
    .m1_x(m1_x), .m1_y(m1_y), .m1_w(m1_w)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_pv;
  logic [7:0] m_code;
  int         m_next;
  bit         m_ovf;
  bit         m_osd_v;
  logic [7:0] m_osd_c;
  logic [7:0] mx[2], my[2], mw[2];
  int         m_phase;
  int         m_sel;
  int         cyc;
  bit         prev_v;
  int         rises[$];
  logic [7:0] rise_codes[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pv = 0; m_code = 0; m_next = 0; m_ovf = 0;
    m_osd_v = 0; m_osd_c = 0; m_phase = 0; m_sel = 0;
    for (int i = 0; i < 2; i++) begin mx[i] = 0; my[i] = 0; mw[i] = 0; end
    prev_v = 0;
  endtask

  task automatic check_all();
    chk("kbd_valid", 32'(kbd_valid), 32'(m_pv));
    chk("kbd_code",  32'(kbd_code),  32'(m_code));
    chk("kbd_ovf",   32'(kbd_ovf),   32'(m_ovf));
    chk("osd_valid", 32'(osd_valid), 32'(m_osd_v));
    chk("osd_code",  32'(osd_code),  32'(m_osd_c));
    chk("m0_x", 32'(m0_x), 32'(mx[0]));
    chk("m0_y", 32'(m0_y), 32'(my[0]));
    chk("m0_w", 32'(m0_w), 32'(mw[0]));
    chk("m1_x", 32'(m1_x), 32'(mx[1]));
    chk("m1_y", 32'(m1_y), 32'(my[1]));
    chk("m1_w", 32'(m1_w), 32'(mw[1]));
  endtask

  // One clock: drive inputs, advance the model over the edge, compare 1 ns later.
  task automatic step(input bit s, input logic [1:0] t, input logic [7:0] d, input bit ix,
                      input bit ack, input bit oack, input bit oclr);
    bit pop, dropped;
    kms_strobe = s; kms_type = t; kms_data = d; kms_idx = ix;
    kbd_ack = ack; osd_ack = oack; ovf_clr = oclr;
    @(posedge clk_sys);
    cyc++;
    pop = !m_pv && (cyc >= m_next) && (mq.size() > 0);
    if (m_pv && ack) begin
      m_pv = 0;
      m_next = cyc + 1 + GAPC;
    end
    if (pop) begin
      m_code = mq.pop_front();
      m_pv = 1;
    end
    dropped = 0;
    if (s && t == 2) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else dropped = 1;
    end
    m_ovf = dropped ? 1'b1 : (oclr ? 1'b0 : m_ovf);
    if (s && t == 3) begin m_osd_c = d; m_osd_v = 1; end
    else if (oack) m_osd_v = 0;
    if (s) begin
      if (t == 0) begin
        mx[ix] = mx[ix] + d; m_phase = 1; m_sel = int'(ix);
      end else if (t == 1) begin
        if (m_phase == 1) begin my[m_sel] = my[m_sel] + d; m_phase = 2; end
        else if (m_phase == 2) begin mw[m_sel] = mw[m_sel] + d; m_phase = 0; end
      end else m_phase = 0;
    end
    #1;
    check_all();
    if (kbd_valid && !prev_v) begin
      rises.push_back(cyc);
      rise_codes.push_back(kbd_code);
    end
    prev_v = kbd_valid;
    kms_strobe = 0; kbd_ack = 0; osd_ack = 0; ovf_clr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    @(posedge clk_sys); @(posedge clk_sys);
    #1;
    reset_n = 1;
  endtask

  initial begin
    logic [7:0] k1 [3];
    int budget;
    k1[0] = 8'h45; k1[1] = 8'h46; k1[2] = 8'h47;
    cyc = 0;
    do_reset();
    check_all();

    // Three keycodes, ack in the presented cycle: 18-cycle spacing between valid rises
    rises.delete(); rise_codes.delete();
    for (int i = 0; i < 60; i++) step(i < 3, 2'd2, (i < 3) ? k1[i] : 8'h00, 0, kbd_valid, 0, 0);
    chk("rise_count", 32'(rises.size()), 32'd3);
    if (rises.size() == 3) begin
      chk("gap01", 32'(rises[1] - rises[0]), 32'd18);
      chk("gap12", 32'(rises[2] - rises[1]), 32'd18);
      for (int i = 0; i < 3; i++) chk("order", 32'(rise_codes[i]), 32'(k1[i]));
    end
    chk("t1_ovf", 32'(kbd_ovf), 32'd0);

    // Overflow: no ack, 10 pushes -> 1 presented + 8 buffered, 10th dropped
    for (int i = 0; i < 10; i++) step(1, 2'd2, 8'(8'h60 + i), 0, 0, 0, 0);
    chk("ovf_set", 32'(kbd_ovf), 32'd1);
    chk("ovf_code", 32'(kbd_code), 32'h60);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("ovf_clr", 32'(kbd_ovf), 32'd0);

    // Full FIFO: push lands exactly on the post-gap pop edge and is accepted
    step(0, 0, 0, 0, 1, 0, 0);
    idle(GAPC);
    step(1, 2'd2, 8'hA5, 0, 0, 0, 0);
    chk("full_pp_ovf", 32'(kbd_ovf), 32'd0);
    chk("full_pp_code", 32'(kbd_code), 32'h61);
    for (int i = 0; i < 200; i++) step(0, 0, 0, 0, kbd_valid, 0, 0);
    chk("drain_last", 32'(kbd_code), 32'hA5);

    // Mouse sequence on mouse 1
    do_reset();
    step(1, 2'd0, 8'h05, 1, 0, 0, 0);
    step(1, 2'd1, 8'hFE, 0, 0, 0, 0);
    step(1, 2'd1, 8'h01, 0, 0, 0, 0);
    step(1, 2'd0, 8'hFF, 1, 0, 0, 0);
    chk("m1_x_dir", 32'(m1_x), 32'h04);
    chk("m1_y_dir", 32'(m1_y), 32'hFE);
    chk("m1_w_dir", 32'(m1_w), 32'h01);
    chk("m0_x_dir", 32'(m0_x), 32'h00);
    step(1, 2'd3, 8'h00, 0, 0, 1, 0);
    step(1, 2'd1, 8'h33, 0, 0, 0, 0);
    chk("ph0_y", 32'(m1_y), 32'hFE);
    chk("ph0_w", 32'(m1_w), 32'h01);
    step(1, 2'd0, 8'hFE, 0, 0, 0, 0);
    step(1, 2'd0, 8'h03, 0, 0, 0, 0);
    chk("m0_wrap", 32'(m0_x), 32'h01);

    // OSD mailbox
    step(1, 2'd3, 8'h12, 0, 0, 0, 0);
    step(1, 2'd3, 8'h34, 0, 0, 0, 0);
    chk("osd_ovw_c", 32'(osd_code), 32'h34);
    chk("osd_ovw_v", 32'(osd_valid), 32'd1);
    step(1, 2'd3, 8'h56, 0, 0, 1, 0);
    chk("osd_race_v", 32'(osd_valid), 32'd1);
    chk("osd_race_c", 32'(osd_code), 32'h56);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("osd_ack", 32'(osd_valid), 32'd0);

    // Asynchronous reset while presenting
    step(1, 2'd2, 8'h77, 0, 0, 0, 0);
    budget = 0;
    while (!kbd_valid && budget < 5) begin step(0, 0, 0, 0, 0, 0, 0); budget++; end
    chk("pres_before_rst", 32'(kbd_valid), 32'd1);
    #3 reset_n = 0;
    #1;
    chk("rst_valid", 32'(kbd_valid), 32'd0);
    chk("rst_code", 32'(kbd_code), 32'd0);
    chk("rst_osd", 32'({osd_valid, osd_code}), 32'd0);
    chk("rst_m0", 32'({m0_x, m0_y, m0_w}), 32'd0);
    chk("rst_m1", 32'({m1_x, m1_y, m1_w}), 32'd0);
    model_reset();
    @(posedge clk_sys); #1;
    reset_n = 1;
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 8'($urandom),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
